// File: rtl/fact_if.sv
// Handshake bundle between a requester and the factorial controller:
// start request with operand, plus busy/done/err status and the result.
interface fact_if;
  logic        go;
  logic [3:0]  n;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;

  modport master (
    output go,
    output n,
    input  busy,
    input  done,
    input  err,
    input  result
  );

  modport slave (
    input  go,
    input  n,
    output busy,
    output done,
    output err,
    output result
  );
endinterface

// File: rtl/fact_ctrl.sv
// Sequential factorial engine: one multiply per cycle, operand range 0..12,
// sticky done/err/result until the next accepted start or reset.
module fact_ctrl (
  input  logic   clk,
  input  logic   rst,
  fact_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_MULT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] MAX_N = 4'd12;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;
  logic [31:0] mult_w;

  // Operands never exceed 12, so the low 32 bits always hold the exact product.
  assign mult_w = prod_q * {28'd0, cnt_q};

  // NOTE: every next-state signal is defaulted to its current value first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          cnt_d    = bus.n;
          prod_d   = 32'd1;
          done_d   = 1'b0;
          err_d    = 1'b0;
          result_d = 32'd0;
          state_d  = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (cnt_q > MAX_N) begin
          err_d    = 1'b1;
          result_d = 32'd0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else if (cnt_q <= 4'd1) begin
          result_d = 32'd1;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_MULT;
        end
      end

      ST_MULT: begin
        prod_d = mult_w;
        cnt_d  = cnt_q - 4'd1;
        // The cnt==2 step is the final multiply; publish it directly.
        if (cnt_q == 4'd2) begin
          result_d = mult_w;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      prod_q   <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_fact_ctrl.sv
// Self-checking bench for fact_ctrl: directed corner runs plus randomized
// runs compared against a cycle-offset reference model of each computation.
module tb_fact_ctrl;

  logic clk;
  logic rst;

  fact_if bus ();

  fact_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Sticky values the outputs must hold while idle.
  logic        exp_done;
  logic        exp_err;
  logic [31:0] exp_res;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_fact(input int v);
    longint acc = 1;
    for (int i = 2; i <= v; i++) acc = acc * i;
    return acc[31:0];
  endfunction

  // Edges from go-accept until done is visible.
  function automatic int ref_latency(input int v);
    return (v <= 1 || v > 12) ? 1 : v;
  endfunction

  task automatic check_all(input string tag, input logic b, input logic d,
                           input logic e, input logic [31:0] r);
    check({tag, ".busy"},   {31'd0, bus.busy}, {31'd0, b});
    check({tag, ".done"},   {31'd0, bus.done}, {31'd0, d});
    check({tag, ".err"},    {31'd0, bus.err},  {31'd0, e});
    check({tag, ".result"}, bus.result, r);
  endtask

  // One full computation; noisy=1 toggles go and scrambles n while busy.
  task automatic run(input int nv, input bit noisy);
    int lat;
    string tag;
    lat = ref_latency(nv);
    exp_err  = (nv > 12);
    exp_res  = exp_err ? 32'd0 : ref_fact(nv);
    exp_done = 1'b1;
    tag = $sformatf("run_n%0d", nv);
    bus.go = 1'b1;
    bus.n  = nv[3:0];
    tick();
    check_all({tag, ".accept"}, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int off = 1; off <= lat + 1; off++) begin
      bus.go = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.n  = 4'($urandom_range(0, 15));
      tick();
      if (off < lat)
        check_all($sformatf("%s.mid%0d", tag, off), 1'b1, 1'b0, 1'b0, 32'd0);
      else if (off == lat)
        check_all({tag, ".done"}, 1'b1, 1'b1, exp_err, exp_res);
      else
        check_all({tag, ".idle"}, 1'b0, 1'b1, exp_err, exp_res);
    end
    bus.go = 1'b0;
  endtask

  task automatic idle(input int cycles);
    bus.go = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      bus.n = 4'($urandom_range(0, 15));
      tick();
      check_all("hold", 1'b0, exp_done, exp_err, exp_res);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.go   = 1'b1;
    bus.n    = 4'd5;
    rst      = 1'b1;

    // Reset wins over a simultaneous go.
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 1'b0, 32'd0);
    rst    = 1'b0;
    bus.go = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_res  = 32'd0;
    idle(2);

    run(5, 1'b0);
    idle(2);
    run(0, 1'b0);
    run(1, 1'b0);
    run(2, 1'b0);
    run(12, 1'b0);
    run(13, 1'b0);
    run(15, 1'b0);
    idle(1);
    run(7, 1'b1);

    // Abort mid-MULT: n=9 accepted at edge k, reset at edge k+4.
    bus.go = 1'b1;
    bus.n  = 4'd9;
    tick();
    bus.go = 1'b0;
    repeat (3) tick();
    check_all("abort.pre", 1'b1, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    tick();
    check_all("abort.rst", 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_res  = 32'd0;
    idle(12);
    run(4, 1'b0);

    // go held high with n=3: each run is accept + 3 edges + DONE + one IDLE.
    bus.go = 1'b1;
    bus.n  = 4'd3;
    tick();
    check_all("held.accept0", 1'b1, 1'b0, 1'b0, 32'd0);
    for (int r = 0; r < 3; r++) begin
      for (int off = 1; off <= ref_latency(3) + 2; off++) begin
        tick();
        if (off < ref_latency(3))
          check_all($sformatf("held%0d.mid", r), 1'b1, 1'b0, 1'b0, 32'd0);
        else if (off == ref_latency(3))
          check_all($sformatf("held%0d.done", r), 1'b1, 1'b1, 1'b0, ref_fact(3));
        else if (off == ref_latency(3) + 1)
          check_all($sformatf("held%0d.idle", r), 1'b0, 1'b1, 1'b0, ref_fact(3));
        else
          check_all($sformatf("held%0d.reaccept", r), 1'b1, 1'b0, 1'b0, 32'd0);
      end
    end
    bus.go = 1'b0;
    repeat (ref_latency(3) + 1) tick();
    check_all("held.final", 1'b0, 1'b1, 1'b0, ref_fact(3));
    exp_done = 1'b1;
    exp_err  = 1'b0;
    exp_res  = ref_fact(3);

    for (int t = 0; t < 40; t++) begin
      run($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
